// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag index and FSM state definitions
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011
  } op_e;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU producing result, {V,C,Z,N} flags and illegal-opcode indication
module Alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   flags_o,
  output logic         illegal_o
);

  logic [N-1:0] b_eff;
  logic         cin;
  logic [N:0]   sum;

  always_comb begin
    cin       = (op_i == OP_SUB);
    b_eff     = cin ? ~b_i : b_i;
    sum       = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, cin};
    result_o  = '0;
    flags_o   = '0;
    illegal_o = 1'b0;
    case (op_e'(op_i))
      OP_ADD, OP_SUB: begin
        result_o        = sum[N-1:0];
        flags_o[FLAG_C] = sum[N];
        // Overflow when both effective addends share a sign the sum does not.
        flags_o[FLAG_V] = (a_i[N-1] == b_eff[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      default: illegal_o = 1'b1;
    endcase
    if (!illegal_o) begin
      flags_o[FLAG_Z] = (result_o == '0);
      flags_o[FLAG_N] = result_o[N-1];
    end
  end

endmodule

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with last-grant pointer
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_id_o = (valid_i == 2'b11) ? ~last_q : valid_i[1];
    grant_o    = 2'b00;
    if (enable_i && (|valid_i)) begin
      grant_o = grant_id_o ? 2'b10 : 2'b01;
    end
    last_d = (|grant_o) ? grant_id_o : last_q;
  end

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester front end sharing one ALU, with response channel and NZCV register
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [N-1:0] req0_a_i,
  input  logic [N-1:0] req0_b_i,
  input  logic [2:0]   req0_op_i,
  input  logic         req0_setf_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [N-1:0] req1_a_i,
  input  logic [N-1:0] req1_b_i,
  input  logic [2:0]   req1_op_i,
  input  logic         req1_setf_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [N-1:0] rsp_result_o,
  output logic [3:0]   rsp_flags_o,
  output logic         rsp_err_o,
  output logic [3:0]   flags_o
);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         setf_q, setf_d;
  logic         id_q, id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_err_q, rsp_err_d;
  logic [3:0]   flags_q, flags_d;

  logic [1:0]   grant;
  logic         grant_id;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         alu_illegal;

  rr_arbiter2 u_arb (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .valid_i    ({req1_valid_i, req0_valid_i}),
    .enable_i   (state_q == IDLE),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  Alu #(.N(N)) u_alu (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (op_q),
    .result_o  (alu_result),
    .flags_o   (alu_flags),
    .illegal_o (alu_illegal)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    setf_d       = setf_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          a_d     = grant_id ? req1_a_i    : req0_a_i;
          b_d     = grant_id ? req1_b_i    : req0_b_i;
          op_d    = grant_id ? req1_op_i   : req0_op_i;
          setf_d  = grant_id ? req1_setf_i : req0_setf_i;
          id_d    = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp_err_d    = alu_illegal;
        if (setf_q && !alu_illegal) begin
          flags_d = alu_flags;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      setf_q       <= 1'b0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      setf_q       <= setf_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      flags_q      <= flags_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign rsp_err_o    = rsp_err_q;
  assign flags_o      = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic       req0_setf = 1'b0, req1_setf = 1'b0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
  logic [3:0] rsp_result, rsp_flags, flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a),
    .req0_b_i(req0_b), .req0_op_i(req0_op), .req0_setf_i(req0_setf),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a),
    .req1_b_i(req1_b), .req1_op_i(req1_op), .req1_setf_i(req1_setf),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err),
    .flags_o(flags)
  );

  typedef struct {
    logic       id;
    logic [3:0] a, b;
    logic [2:0] op;
    logic       setf;
    logic [3:0] res, fl;
    logic       err;
    logic [3:0] flo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic setf);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_setf = setf;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_setf = setf;
    end
  endtask

  task automatic wait_ready(input logic id, input string name);
    bit got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1;
        break;
      end
    end
    check({name, "_ready"}, got, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    set_req(v.id, 1'b1, v.a, v.b, v.op, v.setf);
    wait_ready(v.id, n);
    check({n, "_other_ready"}, v.id ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    set_req(v.id, 1'b0, v.a, v.b, v.op, v.setf);
    @(negedge clk);
    check({n, "_valid_t1"}, rsp_valid, 0);
    @(negedge clk);
    check({n, "_valid_t2"}, rsp_valid, 1);
    check({n, "_id"}, rsp_id, v.id);
    check({n, "_result"}, rsp_result, v.res);
    check({n, "_rflags"}, rsp_flags, v.fl);
    check({n, "_err"}, rsp_err, v.err);
    check({n, "_flags_o"}, flags, v.flo);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  int acc_cyc[4];
  logic acc_id[4];
  int nacc;
  int spurious;

  initial begin
    //                id  a        b        op      setf res      flags    err   flags_o
    vecs[0] = '{1'b0, 4'b0111, 4'b0001, 3'b000, 1'b1, 4'b1000, 4'b1001, 1'b0, 4'b1001};
    vecs[1] = '{1'b1, 4'b0011, 4'b0011, 3'b001, 1'b1, 4'b0000, 4'b0110, 1'b0, 4'b0110};
    vecs[2] = '{1'b1, 4'b1100, 4'b1010, 3'b010, 1'b0, 4'b1000, 4'b0001, 1'b0, 4'b0110};
    vecs[3] = '{1'b0, 4'b0111, 4'b0001, 3'b101, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0110};
    vecs[4] = '{1'b0, 4'b0101, 4'b0010, 3'b011, 1'b1, 4'b0111, 4'b0000, 1'b0, 4'b0000};
    vecs[5] = '{1'b1, 4'b1000, 4'b1000, 3'b000, 1'b1, 4'b0000, 4'b1110, 1'b0, 4'b1110};
    vecs[6] = '{1'b0, 4'b0000, 4'b0001, 3'b001, 1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0001};
    vecs[7] = '{1'b1, 4'b1111, 4'b0001, 3'b111, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001};

    #2;
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_result", rsp_result, 0);
    check("rst_rflags", rsp_flags, 0);
    check("rst_err", rsp_err, 0);
    check("rst_flags_o", flags, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    @(posedge clk);

    // Round-robin alternation with both requesters held valid
    do_reset();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0111, 4'b0001, 3'b000, 1'b1);
    set_req(1'b1, 1'b1, 4'b0001, 4'b0001, 3'b000, 1'b0);
    nacc = 0;
    for (int c = 0; c < 30 && nacc < 4; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        acc_cyc[nacc] = c;
        acc_id[nacc] = req1_ready;
        nacc++;
      end
    end
    check("rr_accepts", nacc, 4);
    check("rr_id0", acc_id[0], 0);
    check("rr_id1", acc_id[1], 1);
    check("rr_id2", acc_id[2], 0);
    check("rr_id3", acc_id[3], 1);
    for (int i = 0; i < 3; i++) check($sformatf("rr_spacing%0d", i), acc_cyc[i+1] - acc_cyc[i], 3);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rr_flags_o", flags, 4'b1001);
    repeat (2) @(posedge clk);

    // Response backpressure: last grant was req1, so req0 next
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 4'b0010, 4'b0011, 3'b000, 1'b0);
    wait_ready(1'b0, "bp");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 4'b0001, 4'b0001, 3'b000, 1'b0);
    @(negedge clk);
    check("bp_exec_ready1", req1_ready, 0);
    @(negedge clk);
    check("bp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), rsp_valid, 1);
      check($sformatf("bp_hold_result%0d", i), rsp_result, 4'b0101);
      check($sformatf("bp_hold_id%0d", i), rsp_id, 0);
      check($sformatf("bp_hold_ready%0d", i), {req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_released_valid", rsp_valid, 0);
    check("bp_released_ready1", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("bp_req1_result", rsp_result, 4'b0010);
    check("bp_req1_id", rsp_id, 1);
    repeat (2) @(posedge clk);

    // Asynchronous reset during EXEC discards the operation
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 4'b0111, 4'b0001, 3'b000, 1'b1);
    wait_ready(1'b1, "rx");
    @(posedge clk); #1;
    req1_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rx_valid", rsp_valid, 0);
    check("rx_result", rsp_result, 0);
    check("rx_id", rsp_id, 0);
    check("rx_flags_o", flags, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) spurious++;
    end
    check("rx_no_response", spurious, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0001, 4'b0001, 3'b000, 1'b0);
    set_req(1'b1, 1'b1, 4'b0001, 4'b0001, 3'b000, 1'b0);
    @(negedge clk);
    check("rx_next_ready0", req0_ready, 1);
    check("rx_next_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
